crc16_calc: RTL

Byte-serial CRC-16 generator that sits directly upstream of the CRC byte sender. It accepts message bytes as they are handed to the coder and folds each one into a running CRC, one bit per clock, MSB first. On the last byte of a message it presents the final 16-bit CRC with a one-cycle ready strobe, which the sender latches and then transmits high byte first.

---
 rtl/crc16_calc.sv | 132 +++++++++++++
 1 files changed

// File: rtl/crc16_calc.sv
// Byte-serial CRC-16/CCITT-FALSE generator, one message bit per clock, MSB first.
// Ports: clk, rst (async, active-high); d/d_rdy/msg_start/msg_last byte input;
// busy (byte in flight or CRC being delivered), crc/crc_rdy final result, err overrun flag.
module crc16_calc #(
    parameter logic [15:0] POLY = 16'h1021,
    parameter logic [15:0] INIT = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  d,
    input  logic        d_rdy,
    input  logic        msg_start,
    input  logic        msg_last,
    output logic        busy,
    output logic [15:0] crc,
    output logic        crc_rdy,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_n;
    logic [15:0] acc;
    logic [15:0] acc_nxt;
    logic [7:0]  sr;
    logic [2:0]  cnt;
    logic        last;
    logic        fb;
    logic        accept;
    logic        shifting;

    // msg_start re-opens the input even while busy, so its byte is taken.
    assign accept   = d_rdy && (state == IDLE || msg_start);
    // msg_start aborts any byte in flight.
    assign shifting = (state == SHIFT) && !msg_start;

    assign fb      = acc[15] ^ sr[7];
    assign acc_nxt = {acc[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        if (msg_start) begin
            state_n = d_rdy ? SHIFT : IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (d_rdy) begin
                        state_n = SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt == 3'd0) begin
                        state_n = last ? DONE : IDLE;
                    end
                end
                DONE: begin
                    state_n = IDLE;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // Output decode
    always_comb begin
        busy = 1'b0;
        unique case (state)
            SHIFT:   busy = 1'b1;
            DONE:    busy = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    // Datapath: accumulator, byte shifter, bit counter, result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= INIT;
            sr      <= 8'h00;
            cnt     <= 3'd0;
            last    <= 1'b0;
            crc     <= 16'h0000;
            crc_rdy <= 1'b0;
            err     <= 1'b0;
        end else begin
            // crc was loaded on entry to DONE, so the strobe trails it by one clock.
            crc_rdy <= (state == DONE) && !msg_start;

            if (msg_start) begin
                err <= 1'b0;
            end else if (d_rdy && busy) begin
                err <= 1'b1;
            end

            if (msg_start) begin
                acc <= INIT;
            end else if (shifting) begin
                acc <= acc_nxt;
            end

            if (accept) begin
                sr   <= d;
                last <= msg_last;
                cnt  <= 3'd7;
            end else if (shifting) begin
                sr  <= {sr[6:0], 1'b0};
                cnt <= cnt - 3'd1;
            end

            if (shifting && cnt == 3'd0 && last) begin
                crc <= acc_nxt;
            end
        end
    end

endmodule
